// File: rtl/matrix_stream_sequencer_if.sv
// Accelerator-side handshake bundle: ap control plus the operand (input_r)
// and result (output_r) AXI-Stream channels. The sequencer owns the master
// modport; the accelerator and result checker sit on the slave side.
interface matrix_stream_sequencer_if;
  logic        ap_start;
  logic        ap_idle;
  logic [31:0] input_r_TDATA_0;
  logic        input_r_TVALID_0;
  logic        input_r_TLAST_0;
  logic        input_r_TREADY_0;
  logic        output_r_TVALID_0;
  logic        output_r_TREADY_0;
  logic        output_r_TLAST_0;

  modport master (
    output ap_start, input_r_TDATA_0, input_r_TVALID_0, input_r_TLAST_0,
    input  ap_idle, input_r_TREADY_0,
    input  output_r_TVALID_0, output_r_TREADY_0, output_r_TLAST_0
  );

  modport slave (
    input  ap_start, input_r_TDATA_0, input_r_TVALID_0, input_r_TLAST_0,
    output ap_idle, input_r_TREADY_0,
    output output_r_TVALID_0, output_r_TREADY_0, output_r_TLAST_0
  );
endinterface

// File: rtl/matrix_stream_sequencer.sv
// Drives an accelerator through a sequence of runs: start handshake, stream
// N_IN_WORDS operand words, then monitor N_OUT_WORDS result beats. A watchdog
// and a result-length check park the block in ERROR with sticky flags.
module matrix_stream_sequencer #(
  parameter int          N_IN_WORDS  = 432,
  parameter int          N_OUT_WORDS = 216,
  parameter logic [31:0] DATA_BASE   = 32'd12,
  parameter int          TIMEOUT     = 20000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                num_runs,
  matrix_stream_sequencer_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                run_count,
  output logic                      timeout_err,
  output logic                      len_err
);

  localparam int W_W  = $clog2(N_IN_WORDS + 1);
  localparam int K_W  = $clog2(N_OUT_WORDS + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [W_W-1:0]  W_LAST = W_W'(N_IN_WORDS - 1);
  localparam logic [K_W-1:0]  K_END  = K_W'(N_OUT_WORDS);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_FEED     = 3'd2;
  localparam logic [2:0] S_WAIT_OUT = 3'd3;
  localparam logic [2:0] S_RUN_DONE = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;

  logic [2:0]      state, nxt;
  logic [W_W-1:0]  w;
  logic [K_W-1:0]  k, k_next;
  logic [WD_W-1:0] wd;
  logic [7:0]      runs_lat, run_next;
  logic            in_beat, out_beat, wd_hit, accept, set_to, set_len;

  // All stream outputs decode from registered state/index, so TREADY never
  // reaches TVALID combinationally and TDATA/TLAST hold while stalled.
  assign bus.ap_start         = (state == S_START);
  assign bus.input_r_TVALID_0 = (state == S_FEED);
  assign bus.input_r_TLAST_0  = (state == S_FEED) && (w == W_LAST);
  assign bus.input_r_TDATA_0  = (state == S_FEED) ? DATA_BASE + 32'(w) : 32'd0;
  assign busy = (state != S_IDLE) && (state != S_ERROR);
  assign done = (state == S_FINISH);

  assign in_beat  = bus.input_r_TVALID_0 & bus.input_r_TREADY_0;
  // Result beats only count while waiting for them; elsewhere they are noise.
  assign out_beat = (state == S_WAIT_OUT) & bus.output_r_TVALID_0 & bus.output_r_TREADY_0;
  assign k_next   = k + 1'b1;
  assign run_next = run_count + 8'd1;
  assign wd_hit   = (wd == WD_MAX);
  assign accept   = start && ((state == S_IDLE) || (state == S_ERROR));

  // Next-state decode; progress wins over a watchdog hit in the same cycle.
  always_comb begin
    nxt     = state;
    set_to  = 1'b0;
    set_len = 1'b0;
    case (state)
      S_IDLE, S_ERROR: if (start) nxt = S_START;
      S_START: begin
        if (!bus.ap_idle)  nxt = S_FEED;
        else if (wd_hit) begin nxt = S_ERROR; set_to = 1'b1; end
      end
      S_FEED: begin
        if (in_beat) begin
          if (bus.input_r_TLAST_0) nxt = S_WAIT_OUT;
        end else if (wd_hit) begin
          nxt = S_ERROR; set_to = 1'b1;
        end
      end
      S_WAIT_OUT: begin
        if (out_beat) begin
          if (bus.output_r_TLAST_0 && (k_next == K_END)) nxt = S_RUN_DONE;
          else if (bus.output_r_TLAST_0 || (k_next == K_END)) begin
            nxt = S_ERROR; set_len = 1'b1;
          end
        end else if (wd_hit) begin
          nxt = S_ERROR; set_to = 1'b1;
        end
      end
      S_RUN_DONE: nxt = (run_next == runs_lat) ? S_FINISH : S_START;
      S_FINISH:   nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  // State, per-run counters, watchdog and sticky status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      w           <= '0;
      k           <= '0;
      wd          <= '0;
      runs_lat    <= 8'd0;
      run_count   <= 8'd0;
      timeout_err <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      state <= nxt;

      if (nxt != state || in_beat || out_beat) wd <= '0;
      else if (state == S_START || state == S_FEED || state == S_WAIT_OUT) wd <= wd + 1'b1;
      else wd <= '0;

      // Word index restarts on every entry to FEED, beat index per run.
      if (state != S_FEED) w <= '0;
      else if (in_beat)    w <= w + 1'b1;

      if (state != S_WAIT_OUT) k <= '0;
      else if (out_beat)       k <= k_next;

      if (accept) begin
        runs_lat    <= (num_runs == 8'd0) ? 8'd1 : num_runs;
        run_count   <= 8'd0;
        timeout_err <= 1'b0;
        len_err     <= 1'b0;
      end else begin
        if (state == S_RUN_DONE) run_count <= run_next;
        if (set_to)  timeout_err <= 1'b1;
        if (set_len) len_err     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_sequencer.sv
// Directed sequence of scenarios with randomized backpressure and result
// pacing; operand words and run/done accounting come from a simple model.
module tb_matrix_stream_sequencer;
  localparam int N_IN    = 432;
  localparam int N_OUT   = 216;
  localparam int BASE    = 12;
  localparam int TIMEOUT = 20000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] num_runs;
  logic       busy, done, timeout_err, len_err;
  logic [7:0] run_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int aps_cnt = 0;
  logic aps_q = 1'b0;

  matrix_stream_sequencer_if bus();

  matrix_stream_sequencer #(
    .N_IN_WORDS(N_IN), .N_OUT_WORDS(N_OUT), .DATA_BASE(32'd12), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_runs(num_runs), .bus(bus),
    .busy(busy), .done(done), .run_count(run_count),
    .timeout_err(timeout_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Count done cycles and ap_start assertions.
  always @(posedge clk) begin
    done_cnt <= done_cnt + (done ? 1 : 0);
    aps_q    <= bus.ap_start;
    if (bus.ap_start && !aps_q) aps_cnt <= aps_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] nr);
    start = 1'b1; num_runs = nr;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One accelerator run: start handshake, consume operands, emit results.
  task automatic do_run(input int rdy_pct, input int n_out, input int last_at);
    int idx, cyc;
    bit started, rdy;
    cyc = 0;
    while (!bus.ap_start && cyc < 200) begin @(negedge clk); cyc++; end
    chk("ap_start_seen", bus.ap_start, 1);
    if (!bus.ap_start) return;
    @(negedge clk);
    bus.ap_idle = 1'b0;
    idx = 0; cyc = 0; started = 0;
    while (idx < N_IN && cyc < 20000) begin
      rdy = ($urandom_range(99) < rdy_pct);
      bus.input_r_TREADY_0 = rdy;
      if (bus.input_r_TVALID_0) begin
        started = 1;
        chk("tdata", bus.input_r_TDATA_0, BASE + idx);
        chk("tlast", bus.input_r_TLAST_0, idx == N_IN - 1);
        if (rdy) idx++;
      end else if (started) begin
        chk("tvalid_held", bus.input_r_TVALID_0, 1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    bus.input_r_TREADY_0 = 1'b0;
    chk("feed_words", idx, N_IN);
    chk("tvalid_wait_out", bus.input_r_TVALID_0, 0);
    bus.output_r_TREADY_0 = 1'b1;
    for (int j = 0; j < n_out; j++) begin
      while ($urandom_range(3) == 0) @(negedge clk);
      bus.output_r_TVALID_0 = 1'b1;
      bus.output_r_TLAST_0  = (j == last_at);
      @(negedge clk);
      bus.output_r_TVALID_0 = 1'b0;
      bus.output_r_TLAST_0  = 1'b0;
    end
    bus.ap_idle = 1'b1;
  endtask

  task automatic do_seq(input logic [7:0] nr, input int rdy_pct);
    int eff, d0, a0;
    eff = (nr == 0) ? 1 : int'(nr);
    d0 = done_cnt; a0 = aps_cnt;
    pulse_start(nr);
    chk("busy_after_start", busy, 1);
    chk("errs_cleared", {timeout_err, len_err}, 0);
    chk("run_count_cleared", run_count, 0);
    for (int r = 0; r < eff; r++) do_run(rdy_pct, N_OUT, N_OUT - 1);
    repeat (4) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("ap_start_count", aps_cnt - a0, eff);
    chk("run_count_final", run_count, eff);
    chk("no_errs", {timeout_err, len_err}, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic err_len(input int n_out, input int last_at);
    int d0;
    d0 = done_cnt;
    pulse_start(1);
    do_run(100, n_out, last_at);
    @(negedge clk);
    chk("len_err_set", len_err, 1);
    chk("len_busy", busy, 0);
    chk("len_ap_start", bus.ap_start, 0);
    chk("len_tvalid", bus.input_r_TVALID_0, 0);
    chk("len_no_timeout", timeout_err, 0);
    chk("len_no_done", done_cnt - d0, 0);
  endtask

  initial begin
    int c;
    reset = 1'b1; start = 1'b0; num_runs = 8'd0;
    bus.ap_idle = 1'b1; bus.input_r_TREADY_0 = 1'b0;
    bus.output_r_TVALID_0 = 1'b0; bus.output_r_TREADY_0 = 1'b0; bus.output_r_TLAST_0 = 1'b0;
    #12;
    chk("rst_outputs", {bus.ap_start, bus.input_r_TVALID_0, bus.input_r_TLAST_0, busy, done,
                        timeout_err, len_err}, 0);
    chk("rst_tdata", bus.input_r_TDATA_0, 0);
    chk("rst_run_count", run_count, 0);
    @(negedge clk); reset = 1'b0;

    // Stray result beats while idle must be ignored.
    bus.output_r_TREADY_0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.output_r_TVALID_0 = 1'b1; bus.output_r_TLAST_0 = i[0];
      @(negedge clk);
    end
    bus.output_r_TVALID_0 = 1'b0; bus.output_r_TLAST_0 = 1'b0;
    chk("idle_beats_ignored", {len_err, busy}, 0);

    do_seq(8'd1, 100);
    do_seq(8'd1, 50);
    do_seq(8'd3, 50);
    do_seq(8'd0, 100);

    err_len(200, 199);
    do_seq(8'd1, 100);
    err_len(N_OUT, -1);
    do_seq(8'd1, 70);

    // Accelerator never leaves idle: watchdog fires.
    pulse_start(1);
    c = 0;
    while (!timeout_err && c < 25000) begin @(negedge clk); c++; end
    chk("timeout_cycles", c, TIMEOUT);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_ap_start", bus.ap_start, 0);
    chk("timeout_busy", busy, 0);

    // Reset asserted mid-FEED clears everything without a clock edge.
    pulse_start(1);
    c = 0;
    while (!bus.ap_start && c < 100) begin @(negedge clk); c++; end
    @(negedge clk); bus.ap_idle = 1'b0;
    c = 0;
    while (!bus.input_r_TVALID_0 && c < 100) begin @(negedge clk); c++; end
    bus.input_r_TREADY_0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_feed_tvalid", bus.input_r_TVALID_0, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_outputs", {bus.ap_start, bus.input_r_TVALID_0, bus.input_r_TLAST_0, busy,
                              done, timeout_err, len_err}, 0);
    chk("async_rst_tdata", bus.input_r_TDATA_0, 0);
    bus.input_r_TREADY_0 = 1'b0; bus.ap_idle = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_quiet", {bus.ap_start, bus.input_r_TVALID_0, busy}, 0);
    do_seq(8'd2, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_stream_sequencer.md
MATRIX_STREAM_SEQUENCER -- requirements
Module: matrix_stream_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- N_IN_WORDS, 432, operand words per run (A then B, 32-bit each).
- N_OUT_WORDS, 216, result words expected per run.
- DATA_BASE, 32'd12, first operand word value.
- TIMEOUT, 20000, watchdog limit in cycles without progress.
REQ-002 SHALL have ports, one per line: name direction width meaning:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to begin a sequence of runs.
- num_runs  in  8  runs per sequence; sampled on accepted start; 0 treated as 1.
- ap_start  out  1  accelerator start request.
- ap_idle  in  1  accelerator idle status.
- input_r_TDATA_0  out  32  operand stream data.
- input_r_TVALID_0  out  1  operand stream valid.
- input_r_TLAST_0  out  1  operand stream last.
- input_r_TREADY_0  in  1  operand stream ready.
- output_r_TVALID_0  in  1  result stream valid (monitored only).
- output_r_TREADY_0  in  1  result stream ready (driven by the checker; monitored only).
- output_r_TLAST_0  in  1  result stream last (monitored only).
- busy  out  1  high in every state except IDLE and ERROR.
- done  out  1  one-cycle pulse when all runs complete.
- run_count  out  8  completed runs in current sequence.
- timeout_err  out  1  sticky watchdog error.
- len_err  out  1  sticky result-length error.

Function
REQ-003 SHALL implement states IDLE, START, FEED, WAIT_OUT, RUN_DONE, FINISH, ERROR.
REQ-004 IDLE: start=1 -> latch num_runs, clear run_count, timeout_err, len_err -> START; same from ERROR; start ignored in all other states.
REQ-005 START: ap_start=1; on ap_idle=0 -> FEED, ap_start low from the next cycle.
REQ-006 FEED: input_r_TVALID_0=1; beat = TVALID & TREADY; word index w counts 0..N_IN_WORDS-1, reset to 0 on each entry to FEED.
REQ-007 input_r_TDATA_0 SHALL equal DATA_BASE + w (32-bit wrap-around); TLAST=1 only while w = N_IN_WORDS-1.
REQ-008 TDATA/TLAST SHALL hold stable while TVALID=1 and TREADY=0; TVALID never drops before the beat.
REQ-009 Beat with TLAST -> WAIT_OUT next cycle, TVALID=0 in WAIT_OUT; no combinational path from TREADY to TVALID.
REQ-010 WAIT_OUT: output beat = output_r_TVALID_0 & output_r_TREADY_0; beat count k starts at 0 per run.
REQ-011 Beat with TLAST and k+1 = N_OUT_WORDS -> RUN_DONE; TLAST with k+1 != N_OUT_WORDS, or k+1 = N_OUT_WORDS without TLAST -> len_err=1, ERROR.
REQ-012 Output beats in any state other than WAIT_OUT SHALL be ignored.
REQ-013 RUN_DONE (one cycle): run_count+1; if new value = latched runs -> FINISH, else -> START.
REQ-014 FINISH (one cycle): done=1 -> IDLE; run_count holds final value until next accepted start.
REQ-015 Watchdog: counter cleared on state change, input beat or output beat; increments in START, FEED, WAIT_OUT; at TIMEOUT-1 -> timeout_err=1, ERROR.
REQ-016 ERROR: ap_start=0, input_r_TVALID_0=0, busy=0; error flags sticky until reset or accepted start.
REQ-017 Watchdog width SHALL be at least ceil(log2(TIMEOUT+1)) bits; w and k widths sized from N_IN_WORDS, N_OUT_WORDS.

Reset
REQ-018 reset=1 SHALL asynchronously force IDLE, ap_start=0, input_r_TVALID_0=0, input_r_TLAST_0=0, input_r_TDATA_0=0, busy=0, done=0, run_count=0, timeout_err=0, len_err=0, all internal counters 0.
REQ-019 reset mid-run SHALL abort immediately with no further beats; first action after release requires a new start.

Verification
REQ-020 start, num_runs=1, TREADY always 1, ap_idle drops 1 cycle after ap_start, 216 result beats with TLAST on the last -> 432 input beats data 12..443, TLAST on 443, done pulse, run_count=1, no errors.
REQ-021 Random TREADY backpressure 50% -> data/TLAST stable while stalled, sequence 12..443 intact, no gaps or repeats.
REQ-022 num_runs=3 -> ap_start asserted 3 times, each FEED restarts at 12, done once after third run, run_count=3; num_runs=0 -> single run.
REQ-023 Result TLAST on beat 200, or 216 beats without TLAST -> len_err=1, ERROR, busy=0; new start clears len_err.
REQ-024 ap_idle held 1 after start (TIMEOUT=20000) -> timeout_err=1 after 20000 cycles, ap_start=0; reset asserted mid-FEED -> all outputs 0 asynchronously.
